// File: rtl/fpu_cvt_from_int.sv
// fpu_cvt_from_int: multi-cycle int32/uint32 to binary32 converter; define FPU_CVT_FAST_NORM_EN for single-cycle normalization
module fpu_cvt_from_int (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        kill_i,
  input  logic        is_unsigned_i,
  input  logic [2:0]  rounding_mode_i,
  input  logic [31:0] int_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        inexact_o
);
  localparam logic [1:0] IDLE = 2'd0, NORM = 2'd1, ROUND = 2'd2;
  logic [1:0] state, state_n;
  logic sign, zero, sign_in, norm_done;
  logic l, g, r, s, nx, inc;
  logic [31:0] mag, mag_in, rnd;
  logic [7:0] expn;
  logic [24:0] sum;
`ifdef FPU_CVT_FAST_NORM_EN
  logic [4:0] lz;
  // leading-zero count of the latched magnitude
  always_comb begin
    lz = '0;
    for (int i = 0; i < 32; i++) if (mag[i]) lz = 5'(31 - i);
  end
  assign norm_done = 1'b1;
`else
  assign norm_done = mag[31];
`endif
  assign sign_in = ~is_unsigned_i & int_i[31];
  assign mag_in  = sign_in ? -int_i : int_i;
  // state register
  always_ff @(posedge clk_i)
    if (!reset_i) state <= IDLE;
    else state <= state_n;
  // next state; kill wins over everything except reset
  always_comb
    state_n = kill_i ? IDLE :
              state == IDLE ? (start_i ? (int_i == 32'd0 ? ROUND : NORM) : IDLE) :
              state == NORM ? (norm_done ? ROUND : NORM) : IDLE;
  // outputs decoded from state
  always_comb busy_o = state != IDLE;
  // round the normalized 24-bit significand using guard/round/sticky
  always_comb begin
    l   = mag[8];
    g   = mag[7];
    r   = mag[6];
    s   = |mag[5:0];
    nx  = g | r | s;
    inc = rounding_mode_i == 3'd0 ? g & (r | s | l) :
          rounding_mode_i == 3'd2 ? sign & nx :
          rounding_mode_i == 3'd3 ? ~sign & nx :
          rounding_mode_i == 3'd4 ? g : 1'b0;
    sum = {1'b0, mag[31:8]} + 25'(inc);
    rnd = {sign, expn + {7'b0, sum[24]}, sum[22:0]};
  end
  // datapath: latch operands, normalize, register the rounded result
  always_ff @(posedge clk_i)
    if (!reset_i) begin
      sign      <= 1'b0;
      zero      <= 1'b0;
      mag       <= '0;
      expn      <= '0;
      done_o    <= 1'b0;
      result_o  <= '0;
      inexact_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (!kill_i) begin
        if (state == IDLE && start_i) begin
          sign <= sign_in;
          mag  <= mag_in;
          expn <= 8'd158;
          zero <= int_i == 32'd0;
        end else if (state == NORM) begin
`ifdef FPU_CVT_FAST_NORM_EN
          mag  <= mag << lz;
          expn <= expn - {3'b0, lz};
`else
          if (!mag[31]) begin
            mag  <= mag << 1;
            expn <= expn - 8'd1;
          end
`endif
        end else if (state == ROUND) begin
          result_o  <= zero ? 32'd0 : rnd;
          inexact_o <= ~zero & nx;
          done_o    <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_fpu_cvt_from_int.sv
// tb_fpu_cvt_from_int: randomized and directed checks of fpu_cvt_from_int against an arithmetic reference model
module tb_fpu_cvt_from_int;
  logic clk_i = 1'b0, reset_i = 1'b0, start_i = 1'b0, kill_i = 1'b0, is_unsigned_i = 1'b0;
  logic [2:0] rounding_mode_i = 3'd0;
  logic [31:0] int_i = 32'd0;
  logic busy_o, done_o, inexact_o;
  logic [31:0] result_o;
  int checks = 0, failures = 0;

  fpu_cvt_from_int dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .kill_i(kill_i),
    .is_unsigned_i(is_unsigned_i), .rounding_mode_i(rounding_mode_i), .int_i(int_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .inexact_o(inexact_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // exact integer magnitude, then round by comparing the discarded remainder to one half ulp
  task automatic ref_model(input logic u, input logic [2:0] rm, input logic [31:0] x,
                           output logic [31:0] res, output logic nx, output int lat);
    logic [63:0] m, q, rem, half;
    logic sgn, up;
    int p, e, sh;
    sgn = !u && x[31];
    m = sgn ? 64'h1_0000_0000 - {32'd0, x} : {32'd0, x};
    if (m == 0) begin
      res = 32'd0; nx = 1'b0; lat = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    if (p <= 23) begin
      q = m << (23 - p); rem = 0; half = 1;
    end else begin
      sh = p - 23; q = m >> sh; rem = m & ((64'd1 << sh) - 1); half = 64'd1 << (sh - 1);
    end
    case (rm)
      3'd0: up = rem > half || (rem == half && q[0]);
      3'd2: up = sgn && rem != 0;
      3'd3: up = !sgn && rem != 0;
      3'd4: up = rem >= half;
      default: up = 1'b0;
    endcase
    q = q + 64'(up);
    e = 127 + p;
    if (q == 64'h100_0000) begin
      q = q >> 1; e++;
    end
    res = {sgn, 8'(e), q[22:0]};
    nx = rem != 0;
`ifdef FPU_CVT_FAST_NORM_EN
    lat = 2;
`else
    lat = 31 - p + 2;
`endif
  endtask

  task automatic run(input logic u, input logic [2:0] rm, input logic [31:0] x);
    logic [31:0] er;
    logic en;
    int el, n;
    ref_model(u, rm, x, er, en, el);
    @(negedge clk_i);
    start_i = 1'b1; is_unsigned_i = u; rounding_mode_i = rm; int_i = x;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    chk("busy_accept", 32'(busy_o), 32'd1);
    chk("done_accept", 32'(done_o), 32'd0);
    n = 0;
    while (!done_o && n < 40) begin
      @(posedge clk_i);
      #1 n++;
    end
    chk("latency", n, el);
    chk("result", result_o, er);
    chk("inexact", 32'(inexact_o), 32'(en));
    chk("busy_done", 32'(busy_o), 32'd0);
  endtask

  initial begin
    int seen;
    logic [31:0] x;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_result", result_o, 32'd0);
    chk("rst_inexact", 32'(inexact_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i) reset_i = 1'b1;
    run(1'b0, 3'd0, 32'h0000_0001);
    run(1'b0, 3'd0, 32'hFFFF_FFFF);
    run(1'b0, 3'd0, 32'h8000_0000);
    run(1'b1, 3'd0, 32'h8000_0000);
    run(1'b1, 3'd0, 32'hFFFF_FFFF);
    run(1'b0, 3'd0, 32'h7FFF_FFFF);
    run(1'b0, 3'd1, 32'h7FFF_FFFF);
    for (int m = 0; m < 8; m++) run(1'b0, 3'(m), 32'h0100_0001);
    run(1'b0, 3'd2, 32'hFEFF_FFFF);
    run(1'b0, 3'd3, 32'hFEFF_FFFF);
    for (int k = 0; k < 300; k++) begin
      x = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) x = -x;
      if ($urandom_range(0, 15) == 0) x = 32'd0;
      run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), x);
    end
    // kill together with start in idle: request must be dropped
    @(negedge clk_i);
    start_i = 1'b1; kill_i = 1'b1; int_i = 32'd5;
    @(posedge clk_i);
    #1 start_i = 1'b0; kill_i = 1'b0;
    chk("kill_start_busy", 32'(busy_o), 32'd0);
    run(1'b0, 3'd0, 32'd0);
    // kill during normalization
    @(negedge clk_i);
    start_i = 1'b1; is_unsigned_i = 1'b0; rounding_mode_i = 3'd0; int_i = 32'd1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    @(negedge clk_i) kill_i = 1'b1;
    @(posedge clk_i);
    #1 kill_i = 1'b0;
    chk("kill_busy", 32'(busy_o), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk_i);
      #1 if (done_o) seen++;
    end
    chk("kill_no_done", seen, 0);
    chk("kill_result", result_o, 32'd0);
    run(1'b0, 3'd0, 32'd1);
    // reset during normalization clears everything
    @(negedge clk_i);
    start_i = 1'b1; int_i = 32'd1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    @(negedge clk_i) reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("midrst_result", result_o, 32'd0);
    chk("midrst_inexact", 32'(inexact_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i) reset_i = 1'b1;
    run(1'b1, 3'd4, 32'h0000_1234);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
